// File: rtl/flip_candidate_sequencer.sv
// Flip candidate sequencer: fetches the occurrence rows of one unsatisfied
// clause's literals, streams them into the flip selector and returns the
// chosen variable to the flip/update stage over a valid/ready handshake.
module flip_candidate_sequencer #(
    parameter int unsigned NUM_VARS                 = 1024,
    parameter int unsigned VAR_BITS                 = $clog2(NUM_VARS + 1),
    parameter int unsigned MAX_CLAUSES_PER_VARIABLE = 20,
    parameter int unsigned NSAT                     = 3,
    parameter int unsigned RD_LAT                   = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                start_i,
    output logic                                ready_o,
    input  logic [NSAT*VAR_BITS-1:0]            var_ids_i,
    output logic                                occ_rd_en_o,
    output logic [VAR_BITS-1:0]                 occ_rd_addr_o,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] occ_broken_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] occ_mask_i,
    output logic [MAX_CLAUSES_PER_VARIABLE-1:0] sel_clause_broken_o,
    output logic [MAX_CLAUSES_PER_VARIABLE-1:0] sel_mask_bits_o,
    output logic [$clog2(NSAT)-1:0]             sel_wr_en_o,
    output logic [NSAT-1:0]                     sel_bv_valid_o,
    input  logic [$clog2(NSAT)-1:0]             sel_selected_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] sel_clause_bits_i,
    output logic                                flip_valid_o,
    input  logic                                flip_ready_i,
    output logic [VAR_BITS-1:0]                 flip_var_o,
    output logic                                flip_none_o,
    output logic [MAX_CLAUSES_PER_VARIABLE-1:0] flip_clause_bits_o
);

    localparam int unsigned MC        = MAX_CLAUSES_PER_VARIABLE;
    localparam int unsigned NSAT_BITS = $clog2(NSAT);
    localparam int unsigned IDS_W     = NSAT * VAR_BITS;
    localparam int unsigned CNT_BITS  = 2;
    localparam logic [NSAT_BITS-1:0] SEL_NONE = '1;

    // Only 3-literal clauses and read latencies 1..4 are supported.
    if (NSAT != 3) begin : g_bad_nsat
        $error("flip_candidate_sequencer: NSAT must be 3");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("flip_candidate_sequencer: RD_LAT must be 1..4");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_DRAIN   = 3'd2,
        S_CAPTURE = 3'd3,
        S_HOLD    = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [IDS_W-1:0]      ids_q, ids_d;
    logic [NSAT-1:0]       id_nz_c;
    logic                  accept_c;
    logic [VAR_BITS-1:0]   sel_lit_c;

    logic                  ready_q, ready_d;
    logic                  rd_en_q, rd_en_d;
    logic [VAR_BITS-1:0]   rd_addr_q, rd_addr_d;
    logic [NSAT_BITS-1:0]  rd_code_q, rd_code_d;
    logic [NSAT-1:0]       bv_q, bv_d;
    logic                  flip_valid_q, flip_valid_d;
    logic [VAR_BITS-1:0]   flip_var_q, flip_var_d;
    logic                  flip_none_q, flip_none_d;
    logic [MC-1:0]         flip_bits_q, flip_bits_d;
    logic [NSAT_BITS-1:0]  tag_q [RD_LAT];

    assign accept_c = start_i && ready_q;

    // Per-literal non-zero flags of the incoming clause.
    always_comb begin
        id_nz_c = '0;
        for (int unsigned k = 0; k < NSAT; k++) begin
            id_nz_c[k] = |var_ids_i[k*VAR_BITS +: VAR_BITS];
        end
    end

    // Variable ID of the literal the selector picked.
    always_comb begin
        sel_lit_c = '0;
        for (int unsigned k = 0; k < NSAT; k++) begin
            if (sel_selected_i == NSAT_BITS'(k)) begin
                sel_lit_c = ids_q[k*VAR_BITS +: VAR_BITS];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; cnt_q indexes the literal in ISSUE and the wait in DRAIN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    cnt_d   = '0;
                    state_d = (|id_nz_c) ? S_ISSUE : S_HOLD;
                end
            end
            S_ISSUE: begin
                if (cnt_q == CNT_BITS'(NSAT - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_BITS'(RD_LAT - 1)) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
            S_CAPTURE: state_d = S_HOLD;
            S_HOLD: begin
                if (flip_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output next-values, decoded from the upcoming state so outputs stay registered.
    always_comb begin
        ids_d        = accept_c ? var_ids_i : ids_q;
        bv_d         = accept_c ? id_nz_c : bv_q;
        ready_d      = (state_d == S_IDLE);
        rd_en_d      = (state_d == S_ISSUE);
        rd_addr_d    = '0;
        rd_code_d    = '0;
        flip_valid_d = (state_d == S_HOLD);
        flip_var_d   = flip_var_q;
        flip_none_d  = flip_none_q;
        flip_bits_d  = flip_bits_q;
        if (rd_en_d) begin
            for (int unsigned k = 0; k < NSAT; k++) begin
                if (cnt_d == CNT_BITS'(k)) begin
                    rd_addr_d = ids_d[k*VAR_BITS +: VAR_BITS];
                end
            end
            rd_code_d = NSAT_BITS'(cnt_d) + NSAT_BITS'(1);
        end
        if (accept_c && !(|id_nz_c)) begin
            flip_var_d  = '0;
            flip_none_d = 1'b1;
            flip_bits_d = '0;
        end else if (state_q == S_CAPTURE) begin
            if (sel_selected_i == SEL_NONE || sel_lit_c == '0) begin
                flip_var_d  = '0;
                flip_none_d = 1'b1;
            end else begin
                flip_var_d  = sel_lit_c;
                flip_none_d = 1'b0;
            end
            flip_bits_d = sel_clause_bits_i;
        end
    end

    // Output and latched-clause registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ids_q        <= '0;
            bv_q         <= '0;
            ready_q      <= 1'b1;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            rd_code_q    <= '0;
            flip_valid_q <= 1'b0;
            flip_var_q   <= '0;
            flip_none_q  <= 1'b0;
            flip_bits_q  <= '0;
        end else begin
            ids_q        <= ids_d;
            bv_q         <= bv_d;
            ready_q      <= ready_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            rd_code_q    <= rd_code_d;
            flip_valid_q <= flip_valid_d;
            flip_var_q   <= flip_var_d;
            flip_none_q  <= flip_none_d;
            flip_bits_q  <= flip_bits_d;
        end
    end

    // Tag pipeline: each read's write-enable code emerges with its memory data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= rd_code_q;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign ready_o             = ready_q;
    assign occ_rd_en_o         = rd_en_q;
    assign occ_rd_addr_o       = rd_addr_q;
    assign sel_wr_en_o         = tag_q[RD_LAT-1];
    assign sel_bv_valid_o      = bv_q;
    assign sel_clause_broken_o = (sel_wr_en_o != '0) ? occ_broken_i : '0;
    assign sel_mask_bits_o     = (sel_wr_en_o != '0) ? occ_mask_i : '0;
    assign flip_valid_o        = flip_valid_q;
    assign flip_var_o          = flip_var_q;
    assign flip_none_o         = flip_none_q;
    assign flip_clause_bits_o  = flip_bits_q;

endmodule
